// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file constants and the write-back entry type used by the scheduler,
// its result FIFO and the bus interface.
package regfile_wb_scheduler_pkg;

  localparam int NUM_REGS  = 15;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    reg_data_t;

  localparam reg_idx_t PC_IDX = 4'hF;

  typedef struct packed {
    reg_idx_t  dest;
    reg_data_t data;
  } wb_entry_t;

  function automatic logic is_pc(input reg_idx_t idx);
    return idx == PC_IDX;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bundles the WB-stage, multi-cycle unit, hazard and register-file signals around the
// scheduler; master is the surrounding pipeline, slave is the scheduler.
interface regfile_wb_scheduler_if;
  import regfile_wb_scheduler_pkg::*;

  logic      pipe_wr_en;
  reg_idx_t  pipe_dest;
  reg_data_t pipe_result;
  logic      pipe_stall;

  logic      mc_issue;
  reg_idx_t  mc_issue_dest;
  logic      mc_issue_ready;

  logic      mc_valid;
  reg_idx_t  mc_dest;
  reg_data_t mc_result;
  logic      mc_ready;

  reg_idx_t  src1;
  reg_idx_t  src2;
  logic      hazard1;
  logic      hazard2;

  reg_idx_t  Dest_WB;
  reg_data_t Result_WB;
  logic      writebackEn;
  logic      illegal_dest;

  modport master (
    output pipe_wr_en, pipe_dest, pipe_result,
    output mc_issue, mc_issue_dest,
    output mc_valid, mc_dest, mc_result,
    output src1, src2,
    input  pipe_stall, mc_issue_ready, mc_ready, hazard1, hazard2,
    input  Dest_WB, Result_WB, writebackEn, illegal_dest
  );

  modport slave (
    input  pipe_wr_en, pipe_dest, pipe_result,
    input  mc_issue, mc_issue_dest,
    input  mc_valid, mc_dest, mc_result,
    input  src1, src2,
    output pipe_stall, mc_issue_ready, mc_ready, hazard1, hazard2,
    output Dest_WB, Result_WB, writebackEn, illegal_dest
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Small circular FIFO holding multi-cycle results ({dest,data}) until they win the
// register-file write port. DEPTH must be a power of two so the pointers wrap naturally.
module wb_result_fifo
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Storage needs no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between the WB stage and buffered
// multi-cycle results, and tracks pending multi-cycle destinations for hazard detection.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input logic                   clk,
  input logic                   rst,
  regfile_wb_scheduler_if.slave bus_if
);

  localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  wb_entry_t           head;
  wb_entry_t           push_entry;
  logic                fifo_full;
  logic                fifo_empty;
  logic                head_valid;
  logic                forced;
  logic                head_grant;
  logic                pipe_grant;
  logic                issue_acc;

  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_d;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS:0]   pending_ext;

  reg_idx_t            dest_wb_q;
  reg_idx_t            dest_wb_d;
  reg_data_t           result_wb_q;
  reg_data_t           result_wb_d;
  logic                wb_en_q;
  logic                wb_en_d;
  logic                from_mc_q;
  logic                from_mc_d;
  logic                illegal_q;
  logic                illegal_d;

  assign push_entry = '{dest: bus_if.mc_dest, data: bus_if.mc_result};

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus_if.mc_valid),
    .push_data_i (push_entry),
    .pop_i       (head_grant),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Pipe has priority unless it is idle or the head has starved for MAX_WAIT cycles.
  assign head_valid = !fifo_empty;
  assign forced     = (wait_cnt_q >= WAIT_LIMIT);
  assign head_grant = head_valid && (!bus_if.pipe_wr_en || forced);
  assign pipe_grant = bus_if.pipe_wr_en && !head_grant;

  // Bit 15 is a constant zero so the PC index never reports a hazard or blocks issue.
  assign pending_ext = {1'b0, pending_q};

  assign bus_if.pipe_stall     = bus_if.pipe_wr_en && head_grant;
  assign bus_if.mc_ready       = !fifo_full;
  assign bus_if.mc_issue_ready = !pending_ext[bus_if.mc_issue_dest];
  assign bus_if.hazard1        = pending_ext[bus_if.src1];
  assign bus_if.hazard2        = pending_ext[bus_if.src2];
  assign bus_if.Dest_WB        = dest_wb_q;
  assign bus_if.Result_WB      = result_wb_q;
  assign bus_if.writebackEn    = wb_en_q;
  assign bus_if.illegal_dest   = illegal_q;

  assign issue_acc = bus_if.mc_issue && bus_if.mc_issue_ready;

  always_comb begin
    wb_en_d     = 1'b0;
    from_mc_d   = 1'b0;
    dest_wb_d   = dest_wb_q;
    result_wb_d = result_wb_q;
    illegal_d   = illegal_q;
    wait_cnt_d  = wait_cnt_q;

    if (head_grant) begin
      if (is_pc(head.dest)) begin
        illegal_d = 1'b1;
      end else begin
        wb_en_d     = 1'b1;
        from_mc_d   = 1'b1;
        dest_wb_d   = head.dest;
        result_wb_d = head.data;
      end
    end else if (pipe_grant) begin
      if (is_pc(bus_if.pipe_dest)) begin
        illegal_d = 1'b1;
      end else begin
        wb_en_d     = 1'b1;
        dest_wb_d   = bus_if.pipe_dest;
        result_wb_d = bus_if.pipe_result;
      end
    end

    if (issue_acc && is_pc(bus_if.mc_issue_dest)) begin
      illegal_d = 1'b1;
    end

    if (!head_valid || head_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < WAIT_LIMIT) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  // A pending bit is released only once its multi-cycle write has been presented.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      set_mask[i] = issue_acc && (bus_if.mc_issue_dest == reg_idx_t'(i));
      clr_mask[i] = wb_en_q && from_mc_q && (dest_wb_q == reg_idx_t'(i));
    end
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      pending_q   <= '0;
      dest_wb_q   <= '0;
      result_wb_q <= '0;
      wb_en_q     <= 1'b0;
      from_mc_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      pending_q   <= pending_d;
      dest_wb_q   <= dest_wb_d;
      result_wb_q <= result_wb_d;
      wb_en_q     <= wb_en_d;
      from_mc_q   <= from_mc_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: stimulus queues expected register-file writes,
// a negedge monitor pops and compares them whenever writebackEn is presented.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  wb_entry_t expQ[$];

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pw, input reg_idx_t pd, input reg_data_t pr,
                               input logic iss, input reg_idx_t idest,
                               input logic mv, input reg_idx_t md, input reg_data_t mr,
                               input reg_idx_t s1, input reg_idx_t s2);
    bus.pipe_wr_en    = pw;
    bus.pipe_dest     = pd;
    bus.pipe_result   = pr;
    bus.mc_issue      = iss;
    bus.mc_issue_dest = idest;
    bus.mc_valid      = mv;
    bus.mc_dest       = md;
    bus.mc_result     = mr;
    bus.src1          = s1;
    bus.src2          = s2;
  endtask

  task automatic idle(input reg_idx_t s1, input reg_idx_t s2);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, s1, s2);
  endtask

  task automatic expectWrite(input reg_idx_t d, input reg_data_t v);
    expQ.push_back('{dest: d, data: v});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, actual, expected);
    end
  endtask

  // Write-port monitor: every presented write must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.writebackEn === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write actual dest=%0d data=%h expected none",
                 bus.Dest_WB, bus.Result_WB);
      end else begin
        wb_entry_t e;
        e = expQ.pop_front();
        if (bus.Dest_WB !== e.dest || bus.Result_WB !== e.data) begin
          errors++;
          $display("[TB] FAIL write_order actual dest=%0d data=%h expected dest=%0d data=%h",
                   bus.Dest_WB, bus.Result_WB, e.dest, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle(4'd0, 4'd0);
    tick();
    tick();
    checkBit("rst_wben", bus.writebackEn, 1'b0);
    checkOutput("rst_dest", 32'(bus.Dest_WB), 32'd0);
    checkOutput("rst_result", bus.Result_WB, 32'd0);
    checkBit("rst_illegal", bus.illegal_dest, 1'b0);
    checkBit("rst_mc_ready", bus.mc_ready, 1'b1);
    checkBit("rst_hazard1", bus.hazard1, 1'b0);
    rst = 1'b0;
    tick();

    $display("[TB] single pipe write");
    applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    expectWrite(4'd3, 32'hDEADBEEF);
    #1 checkBit("t1_stall", bus.pipe_stall, 1'b0);
    tick();
    idle(4'd0, 4'd0);
    #1;
    checkBit("t1_wben", bus.writebackEn, 1'b1);
    checkOutput("t1_dest", 32'(bus.Dest_WB), 32'd3);
    checkOutput("t1_result", bus.Result_WB, 32'hDEADBEEF);
    tick();
    #1;
    checkBit("t1_wben_off", bus.writebackEn, 1'b0);
    checkOutput("t1_dest_hold", 32'(bus.Dest_WB), 32'd3);

    $display("[TB] multi-cycle reservation and writeback");
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 4'd5, 4'd0);
    #1;
    checkBit("t2_issue_ready", bus.mc_issue_ready, 1'b1);
    checkBit("t2_hazard_pre", bus.hazard1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd5, 1'b0, 4'd0, 32'd0, 4'd5, 4'd0);
    #1;
    checkBit("t2_hazard_set", bus.hazard1, 1'b1);
    checkBit("t2_issue_blocked", bus.mc_issue_ready, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd5, 32'h55, 4'd5, 4'd0);
    expectWrite(4'd5, 32'h55);
    #1 checkBit("t2_mc_ready", bus.mc_ready, 1'b1);
    tick();
    idle(4'd5, 4'd0);
    #1;
    checkBit("t2_wben_wait", bus.writebackEn, 1'b0);
    checkBit("t2_hazard_fifo", bus.hazard1, 1'b1);
    tick();
    #1;
    checkBit("t2_wben", bus.writebackEn, 1'b1);
    checkOutput("t2_dest", 32'(bus.Dest_WB), 32'd5);
    checkOutput("t2_result", bus.Result_WB, 32'h55);
    checkBit("t2_hazard_out", bus.hazard1, 1'b1);
    tick();
    #1 checkBit("t2_hazard_clr", bus.hazard1, 1'b0);

    $display("[TB] forced head after starvation");
    tick();
    applyStimulus(1'b1, 4'd1, 32'h100, 1'b0, 4'd0, 1'b1, 4'd12, 32'h66, 4'd0, 4'd0);
    expectWrite(4'd1, 32'h100);
    #1 checkBit("t3_stall_0", bus.pipe_stall, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      applyStimulus(1'b1, reg_idx_t'(i + 1), 32'h100 + 32'(i), 1'b0, 4'd0,
                    1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
      expectWrite(reg_idx_t'(i + 1), 32'h100 + 32'(i));
      #1 checkBit("t3_stall_wait", bus.pipe_stall, 1'b0);
    end
    tick();
    applyStimulus(1'b1, 4'd6, 32'h105, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    expectWrite(4'd12, 32'h66);
    #1 checkBit("t3_stall_forced", bus.pipe_stall, 1'b1);
    tick();
    expectWrite(4'd6, 32'h105);
    #1 checkBit("t3_stall_release", bus.pipe_stall, 1'b0);
    tick();
    idle(4'd0, 4'd0);

    $display("[TB] fifo full backpressure");
    tick();
    applyStimulus(1'b1, 4'd1, 32'h200, 1'b0, 4'd0, 1'b1, 4'd7, 32'h71, 4'd0, 4'd0);
    expectWrite(4'd1, 32'h200);
    #1 checkBit("t4_ready_0", bus.mc_ready, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd1, 32'h201, 1'b0, 4'd0, 1'b1, 4'd8, 32'h82, 4'd0, 4'd0);
    expectWrite(4'd1, 32'h201);
    #1 checkBit("t4_ready_1", bus.mc_ready, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      applyStimulus(1'b1, 4'd1, 32'h200 + 32'(i), 1'b0, 4'd0, 1'b1, 4'd9, 32'h93, 4'd0, 4'd0);
      expectWrite(4'd1, 32'h200 + 32'(i));
      #1 checkBit("t4_ready_full", bus.mc_ready, 1'b0);
    end
    tick();
    applyStimulus(1'b1, 4'd1, 32'h205, 1'b0, 4'd0, 1'b1, 4'd9, 32'h93, 4'd0, 4'd0);
    expectWrite(4'd7, 32'h71);
    #1;
    checkBit("t4_stall_forced", bus.pipe_stall, 1'b1);
    checkBit("t4_ready_pop", bus.mc_ready, 1'b0);
    tick();
    expectWrite(4'd1, 32'h205);
    #1;
    checkBit("t4_stall_release", bus.pipe_stall, 1'b0);
    checkBit("t4_ready_after_pop", bus.mc_ready, 1'b1);
    tick();
    idle(4'd0, 4'd0);
    expectWrite(4'd8, 32'h82);
    tick();
    expectWrite(4'd9, 32'h93);
    tick();

    $display("[TB] PC destination and double reservation");
    tick();
    applyStimulus(1'b1, 4'd15, 32'h0BAD, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd15, 4'd0);
    #1;
    checkBit("t5_stall", bus.pipe_stall, 1'b0);
    checkBit("t5_hazard_pc", bus.hazard1, 1'b0);
    tick();
    idle(4'd0, 4'd0);
    #1;
    checkBit("t5_wben_pc", bus.writebackEn, 1'b0);
    checkBit("t5_illegal", bus.illegal_dest, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 4'd0, 4'd5);
    #1 checkBit("t5_issue_ready", bus.mc_issue_ready, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd5, 1'b0, 4'd0, 32'd0, 4'd0, 4'd5);
    #1;
    checkBit("t5_issue_blocked", bus.mc_issue_ready, 1'b0);
    checkBit("t5_hazard2", bus.hazard2, 1'b1);
    checkBit("t5_illegal_sticky", bus.illegal_dest, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0, 32'd0, 4'd0, 4'd5);
    #1 checkBit("t5_issue_pc_ready", bus.mc_issue_ready, 1'b1);

    $display("[TB] reset mid-operation");
    tick();
    applyStimulus(1'b1, 4'd2, 32'h20, 1'b0, 4'd0, 1'b1, 4'd10, 32'hA0, 4'd0, 4'd5);
    expectWrite(4'd2, 32'h20);
    tick();
    applyStimulus(1'b1, 4'd3, 32'h30, 1'b0, 4'd0, 1'b1, 4'd11, 32'hB0, 4'd0, 4'd5);
    #1 checkBit("t6_ready_one", bus.mc_ready, 1'b1);
    tick();
    idle(4'd0, 4'd5);
    #1;
    checkBit("t6_wben_before", bus.writebackEn, 1'b1);
    checkBit("t6_ready_full", bus.mc_ready, 1'b0);
    checkBit("t6_hazard_before", bus.hazard2, 1'b1);
    rst = 1'b1;
    #1;
    checkBit("t6_wben_rst", bus.writebackEn, 1'b0);
    checkOutput("t6_dest_rst", 32'(bus.Dest_WB), 32'd0);
    checkOutput("t6_result_rst", bus.Result_WB, 32'd0);
    checkBit("t6_illegal_rst", bus.illegal_dest, 1'b0);
    checkBit("t6_hazard_rst", bus.hazard2, 1'b0);
    checkBit("t6_ready_rst", bus.mc_ready, 1'b1);
    checkBit("t6_stall_rst", bus.pipe_stall, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    #1;
    checkBit("t6_wben_after", bus.writebackEn, 1'b0);
    checkBit("t6_hazard_after", bus.hazard2, 1'b0);

    begin
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 20) begin
        tick();
        n++;
      end
    end
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
